apb_ecc_master: RTL and testbench

- APB initiator that drives the ECC encode/decode register block from a simple command/response interface.
- Per command: programs CODEWORD_WIDTH, DATA_IN and (noise ops only) NOISE over APB, then writes CTRL last, which starts the operation.
- Waits for operation_done, captures data_out and returns it on a valid/ready response channel.
- Sits between the test/host sequencer and the ECC top; used by the system bench and by on-chip self-test.

---
 rtl/apb_ecc_master.sv | 204 ++++++++++++++++++++
 tb/tb_apb_ecc_master.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_ecc_master.sv
// APB initiator that programs the ECC register block per command.
// Optional macro ECC_MST_TIMEOUT_EN bounds the wait for operation_done.
module apb_ecc_master #(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int BASE_ADDR       = 0,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [1:0]                 cmd_width,
  input  logic [AMBA_WORD-1:0]       cmd_data,
  input  logic [AMBA_WORD-1:0]       cmd_noise,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  input  logic                       operation_done,
  input  logic [DATA_WIDTH-1:0]      data_out,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic                       rsp_err,
  output logic                       busy
);

  typedef enum logic [2:0] {
    IDLE, SETUP, ACCESS, WAIT_DONE, RESP
  } state_t;

  localparam logic [1:0] IX_CW    = 2'd0;
  localparam logic [1:0] IX_DIN   = 2'd1;
  localparam logic [1:0] IX_NOISE = 2'd2;
  localparam logic [1:0] IX_CTRL  = 2'd3;
  localparam logic [1:0] OP_NOISE = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;

  state_t                     state_q, state_d;
  logic [1:0]                 idx_q, idx_d;
  logic [1:0]                 op_q, width_q;
  logic [AMBA_WORD-1:0]       data_q, noise_q;
  logic [AMBA_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [AMBA_WORD-1:0]       pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0]      rsp_data_q, rsp_data_d;
  logic                       rsp_err_q, rsp_err_d;
  logic                       accept;
  logic                       load_bus;
  logic                       load_rsp;
  logic                       timeout;
  logic [1:0]                 src_width;
  logic [3:0]                 offset;

  assign cmd_ready = rst && (state_q == IDLE);
  assign accept    = cmd_valid && cmd_ready;

`ifdef ECC_MST_TIMEOUT_EN
  localparam int CNT_W =
    (TIMEOUT_CYCLES > 256) ? $clog2(TIMEOUT_CYCLES) : 8;
  logic [CNT_W-1:0] cnt_q;

  // Held at zero outside WAIT_DONE so every entry starts from 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (state_q != WAIT_DONE) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout = (state_q == WAIT_DONE) &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    load_bus   = 1'b0;
    load_rsp   = 1'b0;
    rsp_data_d = '0;
    rsp_err_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d = IX_CW;
          if (cmd_op == OP_ILL) begin
            state_d   = RESP;
            load_rsp  = 1'b1;
            rsp_err_d = 1'b1;
          end else begin
            state_d  = SETUP;
            load_bus = 1'b1;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (idx_q == IX_CTRL) begin
          state_d = WAIT_DONE;
        end else begin
          state_d  = SETUP;
          load_bus = 1'b1;
          if (idx_q == IX_DIN && op_q != OP_NOISE)
            idx_d = IX_CTRL;
          else
            idx_d = idx_q + 2'd1;
        end
      end
      WAIT_DONE: begin
        if (operation_done) begin
          state_d    = RESP;
          load_rsp   = 1'b1;
          rsp_data_d = data_out;
        end else if (timeout) begin
          state_d   = RESP;
          load_rsp  = 1'b1;
          rsp_err_d = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The first write is set up while the command is still on the inputs
  always_comb begin
    src_width = (state_q == IDLE) ? cmd_width : width_q;
    offset    = 4'h0;
    pwdata_d  = AMBA_WORD'(op_q);
    unique case (1'b1)
      (idx_d == IX_CW): begin
        offset   = 4'h8;
        pwdata_d = AMBA_WORD'(src_width);
      end
      (idx_d == IX_DIN): begin
        offset   = 4'h4;
        pwdata_d = data_q;
      end
      (idx_d == IX_NOISE): begin
        offset   = 4'hC;
        pwdata_d = noise_q;
      end
      default: begin
        offset   = 4'h0;
        pwdata_d = AMBA_WORD'(op_q);
      end
    endcase
    paddr_d = AMBA_ADDR_WIDTH'(BASE_ADDR) +
              AMBA_ADDR_WIDTH'(offset);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      op_q       <= '0;
      width_q    <= '0;
      data_q     <= '0;
      noise_q    <= '0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) begin
        op_q    <= cmd_op;
        width_q <= cmd_width;
        data_q  <= cmd_data;
        noise_q <= cmd_noise;
      end
      if (load_bus) begin
        paddr_q  <= paddr_d;
        pwdata_q <= pwdata_d;
      end
      if (load_rsp) begin
        rsp_data_q <= rsp_data_d;
        rsp_err_q  <= rsp_err_d;
      end
    end
  end

  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSEL      = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE   = (state_q == ACCESS);
  assign PWRITE    = PSEL;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_apb_ecc_master.sv
// Bench for apb_ecc_master with an APB/ECC slave model.
// Define ECC_MST_TIMEOUT_EN to also run the timeout scenario.
`timescale 1ns/1ps
module tb_apb_ecc_master;
  localparam int AW = 20;
  localparam int W  = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [1:0] cmd_width = '0;
  logic [W-1:0] cmd_data = '0;
  logic [W-1:0] cmd_noise = '0;
  logic [AW-1:0] PADDR;
  logic [W-1:0] PWDATA;
  logic PSEL, PENABLE, PWRITE;
  logic operation_done;
  logic [DW-1:0] data_out;
  logic rsp_valid;
  logic rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic rsp_err;
  logic busy;

  apb_ecc_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_width(cmd_width),
    .cmd_data(cmd_data), .cmd_noise(cmd_noise),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .operation_done(operation_done), .data_out(data_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [W-1:0]  d;
  } wr_t;
  typedef struct packed {
    logic [DW-1:0] d;
    logic          e;
  } exp_t;

  exp_t exp_q[$];
  wr_t  wr_log[$];
  int   total = 0;
  int   bad = 0;

  function automatic logic [31:0] enc(
    input logic [31:0] d, input logic [1:0] w);
    return {d[28:0], 3'b010} ^ {30'd0, w};
  endfunction
  function automatic logic [31:0] dec(
    input logic [31:0] c, input logic [1:0] w);
    return (c >> 3) + {30'd0, w};
  endfunction
  function automatic logic [31:0] ecc_model(
    input logic [1:0] op, input logic [1:0] w,
    input logic [31:0] d, input logic [31:0] n);
    case (op)
      2'b00:   return enc(d, w);
      2'b01:   return dec(d, w);
      default: return dec(enc(d, w) ^ n, w);
    endcase
  endfunction

  logic [W-1:0]  m_cw = '0, m_din = '0, m_noise = '0;
  logic [DW-1:0] m_out = '0;
  int   done_at = -100;
  int   ctrl_cyc = -1;
  int   setup_cyc = -100;
  int   proto_bad = 0;
  int   psel_cnt = 0;
  logic [AW-1:0] s_addr = '0;
  logic [W-1:0]  s_data = '0;
  logic force_done = 1'b0;
  logic mute = 1'b0;

  assign operation_done = (cyc == done_at) || force_done;
  assign data_out = m_out;

  always @(negedge clk) begin
    if (PSEL) psel_cnt <= psel_cnt + 1;
    if (PSEL && !PENABLE) begin
      setup_cyc <= cyc;
      s_addr    <= PADDR;
      s_data    <= PWDATA;
    end
    if (PSEL && PENABLE && PWRITE) begin
      if (setup_cyc != cyc - 1 || s_addr !== PADDR ||
          s_data !== PWDATA)
        proto_bad <= proto_bad + 1;
      wr_log.push_back(wr_t'{PADDR, PWDATA});
      if (PADDR == 20'h8) m_cw <= PWDATA;
      if (PADDR == 20'h4) m_din <= PWDATA;
      if (PADDR == 20'hC) m_noise <= PWDATA;
      if (PADDR == 20'h0) begin
        ctrl_cyc <= cyc;
        m_out <= ecc_model(PWDATA[1:0], m_cw[1:0], m_din,
                           (PWDATA[1:0] == 2'b10) ? m_noise : '0);
        if (!mute) done_at <= cyc + 3;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [1:0] w,
                       input logic [31:0] d, input logic [31:0] n,
                       output int acc, output bit ok);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_width = w;
    cmd_data  = d;
    cmd_noise = n;
    ok  = 1'b0;
    acc = -1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok  = 1'b1;
        acc = cyc;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int lim, output int rc,
                          output bit ok);
    ok = 1'b0;
    rc = -1;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        rc = cyc;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({PADDR, PWDATA, PSEL, PENABLE, PWRITE, rsp_valid,
         rsp_data, rsp_err, busy, cmd_ready} !== '0) begin
      bad++;
      $display("FAIL reset_outs psel=%b paddr=%h rv=%b busy=%b rdy=%b req all 0",
               PSEL, PADDR, rsp_valid, busy, cmd_ready);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle rdy=%b busy=%b req 1 0",
               cmd_ready, busy);
    end
  endtask

  task automatic test_encode();
    int acc, rc, base, pb, errs;
    bit ok, ok2;
    exp_t e;
    wr_t ew[$];
    ew = '{wr_t'{20'h8, 32'h0}, wr_t'{20'h4, 32'h5},
           wr_t'{20'h0, 32'h0}};
    base = wr_log.size();
    pb = proto_bad;
    exp_q.push_back(exp_t'{ecc_model(2'b00, 2'b00, 32'h5, 32'h0), 1'b0});
    issue(2'b00, 2'b00, 32'h5, 32'h0, acc, ok);
    wait_rsp(40, rc, ok2);
    total++;
    if (!ok || !ok2) begin
      bad++;
      $display("FAIL enc_handshake acc=%b rsp=%b req 1 1", ok, ok2);
    end else begin
      e = exp_q.pop_front();
      total++;
      if (rsp_data !== e.d || rsp_err !== e.e) begin
        bad++;
        $display("FAIL enc_rsp data=%h err=%b req %h %b",
                 rsp_data, rsp_err, e.d, e.e);
      end
    end
    errs = 0;
    if (wr_log.size() != base + 3) errs++;
    else
      for (int i = 0; i < 3; i++)
        if (wr_log[base + i] !== ew[i]) errs++;
    total++;
    if (errs != 0 || proto_bad != pb) begin
      bad++;
      $display("FAIL enc_writes n=%0d errs=%0d proto=%0d req 3 0 0",
               wr_log.size() - base, errs, proto_bad - pb);
    end
    total++;
    if (ctrl_cyc != acc + 6 || rc != ctrl_cyc + 4) begin
      bad++;
      $display("FAIL enc_latency ctrl=+%0d rsp=+%0d req +6 +10",
               ctrl_cyc - acc, rc - acc);
    end
  endtask

  task automatic test_noise();
    int acc, rc, base, errs;
    bit ok, ok2;
    exp_t e;
    wr_t ew[$];
    ew = '{wr_t'{20'h8, 32'h1}, wr_t'{20'h4, 32'h1234},
           wr_t'{20'hC, 32'h1}, wr_t'{20'h0, 32'h2}};
    base = wr_log.size();
    exp_q.push_back(exp_t'{ecc_model(2'b10, 2'b01, 32'h1234, 32'h1), 1'b0});
    issue(2'b10, 2'b01, 32'h1234, 32'h1, acc, ok);
    wait_rsp(40, rc, ok2);
    total++;
    if (!ok || !ok2) begin
      bad++;
      $display("FAIL noise_handshake acc=%b rsp=%b req 1 1", ok, ok2);
    end else begin
      e = exp_q.pop_front();
      total++;
      if (rsp_data !== e.d || rsp_err !== e.e) begin
        bad++;
        $display("FAIL noise_rsp data=%h err=%b req %h %b",
                 rsp_data, rsp_err, e.d, e.e);
      end
    end
    errs = 0;
    if (wr_log.size() != base + 4) errs++;
    else
      for (int i = 0; i < 4; i++)
        if (wr_log[base + i] !== ew[i]) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL noise_writes n=%0d errs=%0d req 4 0",
               wr_log.size() - base, errs);
    end
    total++;
    if (ctrl_cyc != acc + 8) begin
      bad++;
      $display("FAIL noise_latency ctrl=+%0d req +8", ctrl_cyc - acc);
    end
  endtask

  task automatic test_illegal();
    int acc, rc, ps;
    bit ok, ok2;
    exp_t e;
    ps = psel_cnt;
    exp_q.push_back(exp_t'{32'h0, 1'b1});
    issue(2'b11, 2'b10, 32'hDEAD, 32'hBEEF, acc, ok);
    wait_rsp(10, rc, ok2);
    total++;
    if (!ok || !ok2 || rc != acc + 1) begin
      bad++;
      $display("FAIL ill_latency ok=%b%b rsp=+%0d req +1",
               ok, ok2, rc - acc);
    end else begin
      e = exp_q.pop_front();
      total++;
      if (rsp_data !== e.d || rsp_err !== e.e) begin
        bad++;
        $display("FAIL ill_rsp data=%h err=%b req %h %b",
                 rsp_data, rsp_err, e.d, e.e);
      end
    end
    repeat (3) @(negedge clk);
    total++;
    if (psel_cnt != ps) begin
      bad++;
      $display("FAIL ill_psel cycles=%0d req 0", psel_cnt - ps);
    end
  endtask

  task automatic test_spurious();
    int acc, rc;
    bit ok, ok2, hit;
    exp_t e;
    exp_q.push_back(exp_t'{ecc_model(2'b00, 2'b10, 32'h77, 32'h0), 1'b0});
    issue(2'b00, 2'b10, 32'h77, 32'h0, acc, ok);
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      if (PSEL && !PENABLE && PADDR == 20'h4) hit = 1'b1;
    end
    force_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    force_done = 1'b0;
    wait_rsp(40, rc, ok2);
    total++;
    if (!ok || !hit || !ok2 || rc != ctrl_cyc + 4) begin
      bad++;
      $display("FAIL spur_timing hit=%b rsp=%b at ctrl+%0d req ctrl+4",
               hit, ok2, rc - ctrl_cyc);
    end
    if (ok2) begin
      e = exp_q.pop_front();
      total++;
      if (rsp_data !== e.d || rsp_err !== e.e) begin
        bad++;
        $display("FAIL spur_rsp data=%h err=%b req %h %b",
                 rsp_data, rsp_err, e.d, e.e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc, rc;
    bit ok, ok2;
    exp_t e;
    logic [1:0] ops[2] = '{2'b01, 2'b00};
    logic [31:0] ds[2] = '{32'hABC0, 32'h1357};
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(exp_t'{ecc_model(ops[k], 2'b11, ds[k], 0), 1'b0});
      issue(ops[k], 2'b11, ds[k], 32'h0, acc, ok);
      wait_rsp(40, rc, ok2);
      total++;
      if (!ok || !ok2) begin
        bad++;
        $display("FAIL b2b_handshake k=%0d ok=%b%b req 11", k, ok, ok2);
      end else begin
        e = exp_q.pop_front();
        total++;
        if (rsp_data !== e.d || rsp_err !== e.e) begin
          bad++;
          $display("FAIL b2b_rsp k=%0d data=%h err=%b req %h %b",
                   k, rsp_data, rsp_err, e.d, e.e);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int acc, rc;
    bit ok, ok2;
    exp_t e;
    logic [DW-1:0] held;
    @(posedge clk); #1 rsp_ready = 1'b0;
    exp_q.push_back(exp_t'{ecc_model(2'b01, 2'b01, 32'h8888, 0), 1'b0});
    issue(2'b01, 2'b01, 32'h8888, 32'h0, acc, ok);
    wait_rsp(40, rc, ok2);
    total++;
    if (!ok || !ok2) begin
      bad++;
      $display("FAIL bp_handshake ok=%b%b req 11", ok, ok2);
    end else begin
      e = exp_q.pop_front();
      total++;
      if (rsp_data !== e.d || rsp_err !== e.e) begin
        bad++;
        $display("FAIL bp_rsp data=%h err=%b req %h %b",
                 rsp_data, rsp_err, e.d, e.e);
      end
    end
    held = rsp_data;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== held ||
          cmd_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold i=%0d rv=%b data=%h rdy=%b req 1 %h 0",
                 i, rsp_valid, rsp_data, cmd_ready, held);
      end
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_accept rv=%b rdy=%b req 1 0",
               rsp_valid, cmd_ready);
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_idle rv=%b busy=%b rdy=%b req 0 0 1",
               rsp_valid, busy, cmd_ready);
    end
  endtask

  task automatic test_reset_mid();
    int acc, rv_cnt, ps;
    bit ok, hit;
    issue(2'b00, 2'b00, 32'h42, 32'h0, acc, ok);
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      if (PSEL && !PENABLE && PADDR == 20'h4) hit = 1'b1;
    end
    rst = 1'b0;
    #1;
    total++;
    if (!ok || !hit || PSEL !== 1'b0 || PENABLE !== 1'b0 ||
        busy !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid hit=%b psel=%b pen=%b busy=%b req 1 0 0 0",
               hit, PSEL, PENABLE, busy);
    end
    @(posedge clk); #1 rst = 1'b1;
    rv_cnt = 0;
    ps = psel_cnt;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid) rv_cnt++;
    end
    total++;
    if (rv_cnt != 0 || psel_cnt != ps) begin
      bad++;
      $display("FAIL rst_norsp rv_cycles=%0d psel_cycles=%0d req 0 0",
               rv_cnt, psel_cnt - ps);
    end
  endtask

`ifdef ECC_MST_TIMEOUT_EN
  task automatic test_timeout();
    int acc, rc;
    bit ok, ok2;
    exp_t e;
    mute = 1'b1;
    exp_q.push_back(exp_t'{32'h0, 1'b1});
    issue(2'b00, 2'b01, 32'h9, 32'h0, acc, ok);
    wait_rsp(200, rc, ok2);
    total++;
    if (!ok || !ok2 || rc != ctrl_cyc + 65) begin
      bad++;
      $display("FAIL tmo_timing rsp=%b at ctrl+%0d req ctrl+65",
               ok2, rc - ctrl_cyc);
    end
    if (ok2) begin
      e = exp_q.pop_front();
      total++;
      if (rsp_data !== e.d || rsp_err !== e.e) begin
        bad++;
        $display("FAIL tmo_rsp data=%h err=%b req %h %b",
                 rsp_data, rsp_err, e.d, e.e);
      end
    end
    mute = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d req finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_encode();
    test_noise();
    test_illegal();
    test_spurious();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef ECC_MST_TIMEOUT_EN
    test_timeout();
`endif
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left n=%0d req 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
